ttt_move_ctrl: RTL and testbench

Upstream move-entry stage for the tic-tac-toe engine. Converts six raw push-buttons into validated single-cycle move requests (`enable`, `data_in_x`, `data_in_y`, `player`) for the engine, and consumes the engine's `stop_game` flag. It keeps a cursor, a shadow occupancy map and strict player alternation, so the engine only ever receives legal moves.

---
 rtl/ttt_move_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ttt_move_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_move_ctrl.sv
// Purpose: turns six raw buttons into legal one-cycle tic-tac-toe move strobes; optional debounce via TTT_DEBOUNCE_EN.
// Latency: raw edge to press strobe 3 cycles (+DEBOUNCE_CYCLES with TTT_DEBOUNCE_EN), press to enable 1 cycle.
// Backpressure: none; presses outside IDLE are dropped, enable strobes are spaced at least 3 cycles apart.
module ttt_move_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_confirm,
    input  logic       btn_new,
    input  logic       stop_game,
    output logic       enable,
    output logic [1:0] data_in_x,
    output logic [1:0] data_in_y,
    output logic [1:0] player,
    output logic [1:0] cursor_x,
    output logic [1:0] cursor_y,
    output logic [8:0] occupied,
    output logic       move_reject,
    output logic       new_game
);

    // Button bit order: 0 right, 1 left, 2 down, 3 up, 4 confirm, 5 new
    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_UP    = 3;
    localparam int B_CONF  = 4;
    localparam int B_NEW   = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    // A debounce length outside the 16-bit counter range cannot be honoured
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be in 1..65535");
    end

    logic [5:0] btn_raw;
    logic [5:0] sync1, sync2;
    logic [5:0] lvl;
    logic [5:0] lvl_q;
    logic [5:0] press;

    assign btn_raw = {btn_new, btn_confirm, btn_up, btn_down, btn_left, btn_right};

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef TTT_DEBOUNCE_EN
    logic [15:0] db_cnt [6];

    // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl <= '0;
            for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (({1'b0, db_cnt[i]} + 17'd1) >= 17'(DEBOUNCE_CYCLES)) begin
                    lvl[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != 16'hFFFF) begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end
`else
    assign lvl = sync2;
`endif

    // Registered rising-edge detector: one strobe per press however long it is held
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q <= '0;
            press <= '0;
        end else begin
            lvl_q <= lvl;
            press <= lvl & ~lvl_q;
        end
    end

    state_t     state, state_nxt;
    logic       do_latch, do_reject, do_commit;
    logic [3:0] cur_idx, mov_idx;
    logic [1:0] x_nxt, y_nxt;

    assign cur_idx = ({2'b00, cursor_y} * 4'd3) + {2'b00, cursor_x};
    assign mov_idx = ({2'b00, data_in_y} * 4'd3) + {2'b00, data_in_x};
    assign enable  = (state == S_ISSUE);

    function automatic logic [1:0] step(input logic [1:0] pos, input logic inc, input logic dec);
        step = pos;
        if (inc && !dec)      step = (pos == 2'd2) ? 2'd0 : pos + 2'd1;
        else if (dec && !inc) step = (pos == 2'd0) ? 2'd2 : pos - 2'd1;
    endfunction

    assign x_nxt = step(cursor_x, press[B_RIGHT], press[B_LEFT]);
    assign y_nxt = step(cursor_y, press[B_DOWN], press[B_UP]);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and move decisions; new-game overrides everything
    always_comb begin
        state_nxt = state;
        do_latch  = 1'b0;
        do_reject = 1'b0;
        do_commit = 1'b0;
        if (press[B_NEW]) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    // While new_game is high the engine still shows the previous
                    // game's stop_game; it clears at the end of this cycle.
                    if (stop_game && !new_game) begin
                        state_nxt = S_OVER;
                    end else if (press[B_CONF]) begin
                        if (!occupied[cur_idx]) begin
                            do_latch  = 1'b1;
                            state_nxt = S_ISSUE;
                        end else begin
                            do_reject = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    do_commit = 1'b1;
                    state_nxt = S_SETTLE;
                end
                S_SETTLE: state_nxt = stop_game ? S_OVER : S_IDLE;
                S_OVER:   state_nxt = S_OVER;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Cursor, move registers, occupancy and player alternation
    always_ff @(posedge clk) begin
        if (reset) begin
            data_in_x   <= 2'd0;
            data_in_y   <= 2'd0;
            player      <= 2'd0;
            cursor_x    <= 2'd1;
            cursor_y    <= 2'd1;
            occupied    <= '0;
            move_reject <= 1'b0;
            new_game    <= 1'b0;
        end else begin
            new_game    <= press[B_NEW];
            move_reject <= do_reject;
            if (press[B_NEW]) begin
                occupied <= '0;
                player   <= 2'd0;
                cursor_x <= 2'd1;
                cursor_y <= 2'd1;
            end else begin
                cursor_x <= x_nxt;
                cursor_y <= y_nxt;
                // Latch the pre-movement cursor so a simultaneous direction press cannot skew the move
                if (do_latch) begin
                    data_in_x <= cursor_x;
                    data_in_y <= cursor_y;
                end
                if (do_commit) begin
                    occupied[mov_idx] <= 1'b1;
                    player            <= {1'b0, ~player[0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_ttt_move_ctrl.sv
module tb_ttt_move_ctrl;

`ifdef TTT_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif

    // Press masks {new, confirm, up, down, left, right}
    localparam logic [5:0] B_R = 6'b000001;
    localparam logic [5:0] B_L = 6'b000010;
    localparam logic [5:0] B_D = 6'b000100;
    localparam logic [5:0] B_U = 6'b001000;
    localparam logic [5:0] B_C = 6'b010000;
    localparam logic [5:0] B_N = 6'b100000;

    localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                          9'h092, 9'h124, 9'h111, 9'h054};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_confirm = 1'b0, btn_new = 1'b0;
    logic       stop_game = 1'b0;
    logic       enable, move_reject, new_game;
    logic [1:0] data_in_x, data_in_y, player, cursor_x, cursor_y;
    logic [8:0] occupied;

    ttt_move_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_confirm(btn_confirm), .btn_new(btn_new), .stop_game(stop_game),
        .enable(enable), .data_in_x(data_in_x), .data_in_y(data_in_y), .player(player),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .occupied(occupied),
        .move_reject(move_reject), .new_game(new_game)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int en_cnt = 0, rej_cnt = 0, ng_cnt = 0;
    logic [1:0] en_x = 2'd0, en_y = 2'd0, en_p = 2'd0;
    logic [1:0] cx = 2'd1, cy = 2'd1;

    // Pulse monitor: counts every high cycle so stretched pulses show up
    always @(negedge clk) begin
        if (!reset) begin
            if (enable) begin
                en_cnt++;
                en_x = data_in_x;
                en_y = data_in_y;
                en_p = player;
            end
            if (move_reject) rej_cnt++;
            if (new_game) ng_cnt++;
        end
    end

    function automatic logic wins(input logic [8:0] b);
        wins = 1'b0;
        for (int i = 0; i < 8; i++) if ((b & LINES[i]) == LINES[i]) wins = 1'b1;
    endfunction

    // Engine model: registers stop_game one cycle after the winning enable
    logic [8:0] b0 = '0, b1 = '0;
    always @(posedge clk) begin : engine
        logic [8:0] m;
        logic [3:0] idx;
        if (reset || new_game) begin
            b0 <= '0;
            b1 <= '0;
            stop_game <= 1'b0;
        end else if (enable) begin
            idx = 4'(int'(data_in_y) * 3 + int'(data_in_x));
            m = '0;
            m[idx] = 1'b1;
            if (player == 2'd0) begin
                b0 <= b0 | m;
                stop_game <= wins(b0 | m);
            end else begin
                b1 <= b1 | m;
                stop_game <= wins(b1 | m);
            end
        end
    end

    task automatic press(input logic [5:0] m);
        @(negedge clk);
        {btn_new, btn_confirm, btn_up, btn_down, btn_left, btn_right} = m;
        repeat (D + 2) @(negedge clk);
        {btn_new, btn_confirm, btn_up, btn_down, btn_left, btn_right} = 6'b0;
        repeat (D + 8) @(negedge clk);
    endtask

    task automatic goto(input logic [1:0] tx, input logic [1:0] ty);
        for (int i = 0; i < 3 && cx != tx; i++) begin
            press(B_R);
            cx = (cx == 2'd2) ? 2'd0 : cx + 2'd1;
        end
        for (int i = 0; i < 3 && cy != ty; i++) begin
            press(B_D);
            cy = (cy == 2'd2) ? 2'd0 : cy + 2'd1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL rst_enable actual=%0b expected=0", enable); end
        checks++; if (data_in_x !== 2'd0) begin failures++; $display("FAIL rst_data_x actual=%0d expected=0", data_in_x); end
        checks++; if (data_in_y !== 2'd0) begin failures++; $display("FAIL rst_data_y actual=%0d expected=0", data_in_y); end
        checks++; if (player !== 2'd0) begin failures++; $display("FAIL rst_player actual=%0d expected=0", player); end
        checks++; if (cursor_x !== 2'd1) begin failures++; $display("FAIL rst_cursor_x actual=%0d expected=1", cursor_x); end
        checks++; if (cursor_y !== 2'd1) begin failures++; $display("FAIL rst_cursor_y actual=%0d expected=1", cursor_y); end
        checks++; if (occupied !== 9'h000) begin failures++; $display("FAIL rst_occupied actual=%0h expected=0", occupied); end
        checks++; if (move_reject !== 1'b0) begin failures++; $display("FAIL rst_reject actual=%0b expected=0", move_reject); end
        checks++; if (new_game !== 1'b0) begin failures++; $display("FAIL rst_new_game actual=%0b expected=0", new_game); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_move;
        int e0;
        e0 = en_cnt;
        btn_confirm = 1'b1;
        repeat (3 + D) @(negedge clk);
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL first_enable_early actual=%0b expected=0", enable); end
        @(negedge clk);
        checks++; if (enable !== 1'b1) begin failures++; $display("FAIL first_enable_latency actual=%0b expected=1", enable); end
        checks++; if (data_in_x !== 2'd1) begin failures++; $display("FAIL first_x actual=%0d expected=1", data_in_x); end
        checks++; if (data_in_y !== 2'd1) begin failures++; $display("FAIL first_y actual=%0d expected=1", data_in_y); end
        checks++; if (player !== 2'd0) begin failures++; $display("FAIL first_player actual=%0d expected=0", player); end
        btn_confirm = 1'b0;
        @(negedge clk);
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL first_enable_width actual=%0b expected=0", enable); end
        checks++; if (player !== 2'd1) begin failures++; $display("FAIL first_player_toggle actual=%0d expected=1", player); end
        checks++; if (occupied !== 9'h010) begin failures++; $display("FAIL first_occupied actual=%0h expected=010", occupied); end
        repeat (D + 8) @(negedge clk);
        checks++; if (en_cnt - e0 !== 1) begin failures++; $display("FAIL first_enable_count actual=%0d expected=1", en_cnt - e0); end
    endtask

    task automatic test_cursor;
        press(B_R);
        checks++; if (cursor_x !== 2'd2) begin failures++; $display("FAIL cur_right actual=%0d expected=2", cursor_x); end
        press(B_R);
        checks++; if (cursor_x !== 2'd0) begin failures++; $display("FAIL cur_right_wrap actual=%0d expected=0", cursor_x); end
        press(B_U);
        checks++; if (cursor_y !== 2'd0) begin failures++; $display("FAIL cur_up actual=%0d expected=0", cursor_y); end
        press(B_U);
        checks++; if (cursor_y !== 2'd2) begin failures++; $display("FAIL cur_up_wrap actual=%0d expected=2", cursor_y); end
        press(B_U | B_D);
        checks++; if (cursor_y !== 2'd2) begin failures++; $display("FAIL cur_updown_cancel actual=%0d expected=2", cursor_y); end
        press(B_L | B_D);
        checks++; if (cursor_x !== 2'd2) begin failures++; $display("FAIL cur_both_x actual=%0d expected=2", cursor_x); end
        checks++; if (cursor_y !== 2'd0) begin failures++; $display("FAIL cur_both_y actual=%0d expected=0", cursor_y); end
        press(B_L | B_R);
        checks++; if (cursor_x !== 2'd2) begin failures++; $display("FAIL cur_lr_cancel actual=%0d expected=2", cursor_x); end
        cx = 2'd2;
        cy = 2'd0;
    endtask

    task automatic test_reject;
        int e0, r0;
        goto(2'd1, 2'd1);
        e0 = en_cnt;
        r0 = rej_cnt;
        press(B_C);
        checks++; if (rej_cnt - r0 !== 1) begin failures++; $display("FAIL reject_pulse actual=%0d expected=1", rej_cnt - r0); end
        checks++; if (en_cnt - e0 !== 0) begin failures++; $display("FAIL reject_no_enable actual=%0d expected=0", en_cnt - e0); end
        checks++; if (player !== 2'd1) begin failures++; $display("FAIL reject_player actual=%0d expected=1", player); end
    endtask

    task automatic test_new_game_discard;
        int e0, r0, n0;
        e0 = en_cnt; r0 = rej_cnt; n0 = ng_cnt;
        press(B_N | B_C | B_R);
        cx = 2'd1; cy = 2'd1;
        checks++; if (ng_cnt - n0 !== 1) begin failures++; $display("FAIL ng_pulse actual=%0d expected=1", ng_cnt - n0); end
        checks++; if (en_cnt - e0 !== 0 || rej_cnt - r0 !== 0) begin failures++; $display("FAIL ng_discard actual=%0d expected=0", (en_cnt - e0) + (rej_cnt - r0)); end
        checks++; if (occupied !== 9'h000) begin failures++; $display("FAIL ng_occupied actual=%0h expected=0", occupied); end
        checks++; if (player !== 2'd0) begin failures++; $display("FAIL ng_player actual=%0d expected=0", player); end
        checks++; if ({cursor_x, cursor_y} !== 4'b0101) begin failures++; $display("FAIL ng_cursor actual=%0d,%0d expected=1,1", cursor_x, cursor_y); end
    endtask

    task automatic test_win;
        int e0, r0;
        logic [1:0] mx [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        logic [1:0] my [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        e0 = en_cnt;
        for (int i = 0; i < 5; i++) begin
            goto(mx[i], my[i]);
            press(B_C);
        end
        checks++; if (en_cnt - e0 !== 5) begin failures++; $display("FAIL win_enables actual=%0d expected=5", en_cnt - e0); end
        checks++; if (stop_game !== 1'b1) begin failures++; $display("FAIL win_stop actual=%0b expected=1", stop_game); end
        checks++; if (occupied !== 9'h01F) begin failures++; $display("FAIL win_occupied actual=%0h expected=01f", occupied); end
        checks++; if (player !== 2'd1) begin failures++; $display("FAIL win_player actual=%0d expected=1", player); end
        e0 = en_cnt; r0 = rej_cnt;
        goto(2'd2, 2'd2);
        press(B_C);
        goto(2'd0, 2'd0);
        press(B_C);
        checks++; if (en_cnt - e0 !== 0) begin failures++; $display("FAIL over_no_enable actual=%0d expected=0", en_cnt - e0); end
        checks++; if (rej_cnt - r0 !== 0) begin failures++; $display("FAIL over_no_reject actual=%0d expected=0", rej_cnt - r0); end
        checks++; if ({cursor_x, cursor_y} !== 4'b0000) begin failures++; $display("FAIL over_cursor_moves actual=%0d,%0d expected=0,0", cursor_x, cursor_y); end
    endtask

    task automatic test_new_game_over;
        int n0, e0;
        n0 = ng_cnt;
        @(negedge clk);
        btn_new = 1'b1;
        repeat (D + 20) @(negedge clk);
        btn_new = 1'b0;
        repeat (D + 8) @(negedge clk);
        cx = 2'd1; cy = 2'd1;
        checks++; if (ng_cnt - n0 !== 1) begin failures++; $display("FAIL over_ng_once actual=%0d expected=1", ng_cnt - n0); end
        checks++; if (occupied !== 9'h000) begin failures++; $display("FAIL over_ng_occupied actual=%0h expected=0", occupied); end
        checks++; if (player !== 2'd0) begin failures++; $display("FAIL over_ng_player actual=%0d expected=0", player); end
        checks++; if ({cursor_x, cursor_y} !== 4'b0101) begin failures++; $display("FAIL over_ng_cursor actual=%0d,%0d expected=1,1", cursor_x, cursor_y); end
        e0 = en_cnt;
        press(B_C);
        checks++; if (en_cnt - e0 !== 1) begin failures++; $display("FAIL over_ng_accept actual=%0d expected=1", en_cnt - e0); end
        checks++; if ({en_x, en_y, en_p} !== 6'b010100) begin failures++; $display("FAIL over_ng_move actual=%0d,%0d,%0d expected=1,1,0", en_x, en_y, en_p); end
    endtask

    task automatic test_reset_mid_issue;
        bit seen;
        goto(2'd0, 2'd0);
        @(negedge clk);
        btn_confirm = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (enable === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL mid_issue_timeout actual=0 expected=1"); end
        reset = 1'b1;
        @(negedge clk);
        btn_confirm = 1'b0;
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL mid_issue_enable actual=%0b expected=0", enable); end
        checks++; if (occupied !== 9'h000) begin failures++; $display("FAIL mid_issue_occupied actual=%0h expected=0", occupied); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cx = 2'd1; cy = 2'd1;
        repeat (2) @(negedge clk);
    endtask

`ifdef TTT_DEBOUNCE_EN
    task automatic test_debounce;
        logic [6:0] bounce = 7'b1111101;
        @(negedge clk);
        btn_right = 1'b1;
        repeat (3) @(negedge clk);
        btn_right = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (cursor_x !== 2'd1) begin failures++; $display("FAIL db_glitch actual=%0d expected=1", cursor_x); end
        btn_right = 1'b1;
        repeat (6) @(negedge clk);
        btn_right = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (cursor_x !== 2'd2) begin failures++; $display("FAIL db_pulse actual=%0d expected=2", cursor_x); end
        for (int i = 0; i < 7; i++) begin
            btn_right = bounce[i];
            @(negedge clk);
        end
        btn_right = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (cursor_x !== 2'd0) begin failures++; $display("FAIL db_bounce actual=%0d expected=0", cursor_x); end
        cx = 2'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_first_move();
        test_cursor();
        test_reject();
        test_new_game_discard();
        test_win();
        test_new_game_over();
        test_reset_mid_issue();
`ifdef TTT_DEBOUNCE_EN
        test_debounce();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
